x_uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each single-cycle byte strobe from the receiver into a circular FIFO and presents the bytes to the consumer over a show-ahead valid/ready interface. It also provides a sticky overflow flag, an occupancy count, and an idle-line timeout pulse so the consumer can detect the end of a burst.

---
 rtl/x_uart_rx_fifo_if.sv | 29 ++
 rtl/x_uart_rx_fifo.sv | 139 +++++++++++++
 tb/tb_x_uart_rx_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/x_uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the RX FIFO and its consumer.
// Signal names keep the original block's port names so existing hookups map one-to-one.
interface x_uart_rx_fifo_if #(
  parameter int unsigned p_depth = 16
) ();
  localparam int unsigned p_cnt_width = $clog2(p_depth) + 1;

  logic                   i_valid;
  logic [7:0]             i_data;
  logic                   o_valid;
  logic [7:0]             o_data;
  logic                   i_ready;
  logic [p_cnt_width-1:0] o_count;
  logic                   o_overflow;
  logic                   i_clr_overflow;
  logic                   o_timeout;

  // FIFO side
  modport slave (
    input  i_valid, i_data, i_ready, i_clr_overflow,
    output o_valid, o_data, o_count, o_overflow, o_timeout
  );

  // Receiver/consumer side
  modport master (
    output i_valid, i_data, i_ready, i_clr_overflow,
    input  o_valid, o_data, o_count, o_overflow, o_timeout
  );
endinterface

// File: rtl/x_uart_rx_fifo.sv
// UART receive FIFO: captures single-cycle byte strobes into a circular buffer,
// presents the head byte show-ahead, flags dropped bytes and pulses on an idle line.
module x_uart_rx_fifo #(
  parameter int unsigned p_depth       = 16,
  parameter int unsigned p_idle_cycles = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  x_uart_rx_fifo_if.slave   io_bus
);
  localparam int unsigned p_cnt_width = $clog2(p_depth) + 1;
  localparam int unsigned p_aw        = $clog2(p_depth);
  localparam int unsigned p_tw        = $clog2(p_idle_cycles) + 1;

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } t_state;

  logic [7:0]             r_mem [p_depth];
  logic [p_aw-1:0]        r_wr_ptr;
  logic [p_aw-1:0]        r_rd_ptr;
  logic [p_cnt_width-1:0] r_count;
  logic [7:0]             r_data;
  logic                   r_overflow;
  logic                   r_timeout;
  logic [p_tw-1:0]        r_timer;
  t_state                 r_state;

  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [p_aw-1:0]        w_rd_next;
  logic [7:0]             w_head_next;
  logic [p_cnt_width-1:0] w_count_next;

  assign w_pop  = (r_count != '0) & io_bus.i_ready;
  assign w_push = io_bus.i_valid & ((r_count < p_cnt_width'(p_depth)) | w_pop);
  assign w_drop = io_bus.i_valid & ~w_push;

  // Next head pointer and next head byte; the head register is refreshed every edge
  // so o_data is a clean flop output. A write landing on the next head slot bypasses
  // the array read, which covers the empty-FIFO first-word case.
  always_comb begin
    w_rd_next   = w_pop ? r_rd_ptr + p_aw'(1) : r_rd_ptr;
    w_head_next = r_mem[w_rd_next];
    if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_next = io_bus.i_data;
    end
  end

  // Occupancy update: both or neither leaves the count unchanged
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + p_cnt_width'(1);
      2'b01:   w_count_next = r_count - p_cnt_width'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage array write port (contents intentionally not reset)
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_bus.i_data;
    end
  end

  // Pointers, occupancy and registered head byte
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + p_aw'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_data   <= w_head_next;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (io_bus.i_clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Idle-line timer: armed by accepted writes, disarmed by a full drain or by firing
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_state <= S_ARMED;
            r_timer <= '0;
          end
        end
        S_ARMED: begin
          if (w_count_next == '0) begin
            r_state <= S_IDLE;
            r_timer <= '0;
          end else if (w_push) begin
            r_timer <= '0;
          end else if (r_timer == p_tw'(p_idle_cycles - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
            r_timer   <= '0;
          end else if (r_timer < p_tw'(p_idle_cycles - 1)) begin
            r_timer <= r_timer + p_tw'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign io_bus.o_valid    = (r_count != '0);
  assign io_bus.o_data     = r_data;
  assign io_bus.o_count    = r_count;
  assign io_bus.o_overflow = r_overflow;
  assign io_bus.o_timeout  = r_timeout;
endmodule

// File: tb/tb_x_uart_rx_fifo.sv
// Directed bench for x_uart_rx_fifo with a short idle timeout.
module tb_x_uart_rx_fifo;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  x_uart_rx_fifo_if #(.p_depth(16)) u_if ();

  x_uart_rx_fifo #(.p_depth(16), .p_idle_cycles(10)) u_dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .io_bus (u_if.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    u_if.i_valid        = 1'b0;
    u_if.i_data         = 8'h00;
    u_if.i_ready        = 1'b0;
    u_if.i_clr_overflow = 1'b0;
    tick();
    check("rst_valid", 32'(u_if.o_valid), 0);
    check("rst_data", 32'(u_if.o_data), 0);
    check("rst_count", 32'(u_if.o_count), 0);
    check("rst_ovf", 32'(u_if.o_overflow), 0);
    check("rst_tmo", 32'(u_if.o_timeout), 0);
    i_rst = 1'b1;
    tick();

    // Single byte, held, then popped
    u_if.i_valid = 1'b1; u_if.i_data = 8'hA5;
    tick();
    u_if.i_valid = 1'b0;
    check("one_valid", 32'(u_if.o_valid), 1);
    check("one_data", 32'(u_if.o_data), 32'hA5);
    check("one_count", 32'(u_if.o_count), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_valid", 32'(u_if.o_valid), 1);
      check("hold_data", 32'(u_if.o_data), 32'hA5);
      check("hold_count", 32'(u_if.o_count), 1);
    end
    u_if.i_ready = 1'b1;
    tick();
    u_if.i_ready = 1'b0;
    check("pop_valid", 32'(u_if.o_valid), 0);
    check("pop_count", 32'(u_if.o_count), 0);

    // Fill to 16, then one dropped byte
    for (int k = 0; k < 16; k++) begin
      u_if.i_valid = 1'b1; u_if.i_data = 8'(k);
      tick();
    end
    u_if.i_data = 8'hFF;
    tick();
    u_if.i_valid = 1'b0;
    check("full_count", 32'(u_if.o_count), 16);
    check("full_ovf", 32'(u_if.o_overflow), 1);
    check("full_head", 32'(u_if.o_data), 32'h00);

    // Drop and clear together: set wins; then clear alone
    u_if.i_valid = 1'b1; u_if.i_data = 8'hEE; u_if.i_clr_overflow = 1'b1;
    tick();
    u_if.i_valid = 1'b0;
    check("drop_clr_ovf", 32'(u_if.o_overflow), 1);
    check("drop_clr_count", 32'(u_if.o_count), 16);
    tick();
    u_if.i_clr_overflow = 1'b0;
    check("clr_ovf", 32'(u_if.o_overflow), 0);

    // Full with simultaneous pop and push
    u_if.i_valid = 1'b1; u_if.i_data = 8'h77; u_if.i_ready = 1'b1;
    tick();
    u_if.i_valid = 1'b0; u_if.i_ready = 1'b0;
    check("fullpp_count", 32'(u_if.o_count), 16);
    check("fullpp_ovf", 32'(u_if.o_overflow), 0);
    check("fullpp_head", 32'(u_if.o_data), 32'h01);

    // Drain: 01..0F then 77, FFs/EEs absent
    u_if.i_ready = 1'b1;
    for (int k = 1; k < 17; k++) begin
      check("drain_valid", 32'(u_if.o_valid), 1);
      check("drain_data", 32'(u_if.o_data), (k == 16) ? 32'h77 : 32'(k));
      tick();
    end
    u_if.i_ready = 1'b0;
    check("drain_empty", 32'(u_if.o_valid), 0);
    check("drain_count", 32'(u_if.o_count), 0);

    // Pointers have wrapped; round trip still works
    u_if.i_valid = 1'b1; u_if.i_data = 8'h55;
    tick();
    u_if.i_valid = 1'b0;
    check("wrap_data", 32'(u_if.o_data), 32'h55);
    check("wrap_count", 32'(u_if.o_count), 1);
    u_if.i_ready = 1'b1;
    tick();
    u_if.i_ready = 1'b0;
    check("wrap_empty", 32'(u_if.o_count), 0);

    // Timeout: single push, pulse 10 cycles later exactly once
    u_if.i_valid = 1'b1; u_if.i_data = 8'h11;
    tick();
    u_if.i_valid = 1'b0;
    check("tmo_a_0", 32'(u_if.o_timeout), 0);
    for (int k = 1; k <= 13; k++) begin
      tick();
      check("tmo_a", 32'(u_if.o_timeout), (k == 10) ? 1 : 0);
    end
    u_if.i_ready = 1'b1;
    tick();
    u_if.i_ready = 1'b0;

    // Timeout: second push at cycle 5 restarts the window
    u_if.i_valid = 1'b1; u_if.i_data = 8'h22;
    tick();
    u_if.i_valid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      u_if.i_valid = (k == 5);
      u_if.i_data  = 8'h33;
      tick();
      u_if.i_valid = 1'b0;
      check("tmo_b", 32'(u_if.o_timeout), (k == 15) ? 1 : 0);
    end
    check("tmo_b_count", 32'(u_if.o_count), 2);
    u_if.i_ready = 1'b1;
    tick();
    tick();
    u_if.i_ready = 1'b0;
    check("tmo_b_empty", 32'(u_if.o_count), 0);

    // Timeout: drained before expiry, no pulse
    u_if.i_valid = 1'b1; u_if.i_data = 8'h44;
    tick();
    u_if.i_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      u_if.i_ready = (k == 3);
      tick();
      u_if.i_ready = 1'b0;
      check("tmo_c", 32'(u_if.o_timeout), 0);
    end

    // Asynchronous reset mid-burst with overflow set
    for (int k = 0; k < 17; k++) begin
      u_if.i_valid = 1'b1; u_if.i_data = 8'(8'hC0 + k);
      tick();
    end
    u_if.i_valid = 1'b0;
    u_if.i_ready = 1'b1;
    for (int k = 0; k < 11; k++) tick();
    u_if.i_ready = 1'b0;
    check("pre_rst_count", 32'(u_if.o_count), 5);
    check("pre_rst_ovf", 32'(u_if.o_overflow), 1);
    #2 i_rst = 1'b0;
    #1;
    check("arst_valid", 32'(u_if.o_valid), 0);
    check("arst_count", 32'(u_if.o_count), 0);
    check("arst_ovf", 32'(u_if.o_overflow), 0);
    check("arst_data", 32'(u_if.o_data), 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
    check("post_rst_valid", 32'(u_if.o_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
